// File: rtl/uart_pkg.sv
// Shared UART constants and the transmitter state encoding.
// The receiver picks these up as well, so framing stays defined in one place.
package uart_pkg;

  localparam int BIT_TICKS  = 16;
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: holding register fed by a rising-edge write strobe, shift
// register serialising start / 8 data LSB-first / parity / stop at 16 clocks per bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int PARITYMODE = 1
) (
  input  logic       mclkx16,
  input  logic       reset,
  input  logic       write,
  input  logic [7:0] data,
  output logic       tx,
  output logic       txrdy,
  output logic       txempty,
  output logic [2:0] state
);

  localparam logic PAR_INIT = (PARITYMODE != 0);

  tx_state_t  st, nst;
  logic [3:0] cnt;
  logic [2:0] bitidx, nidx;
  logic [7:0] thr, tsr, ntsr;
  logic       thr_full;
  logic       par, npar;
  logic       write2;
  logic       load;
  logic       last;
  logic       tx_d;
  logic       wedge;

  assign wedge   = write & ~write2;
  assign last    = (cnt == 4'(BIT_TICKS - 1));
  assign txrdy   = ~thr_full;
  assign txempty = (st == IDLE) && !thr_full;
  assign state   = st;

  always_comb begin
    nst  = st;
    ntsr = tsr;
    npar = par;
    nidx = bitidx;
    load = 1'b0;
    case (st)
      IDLE:   if (thr_full) begin load = 1'b1; nst = START; end
      START:  if (last) begin nst = DATA; nidx = 3'd0; end
      DATA:   if (last) begin
                ntsr = tsr >> 1;
                npar = par ^ tsr[0];
                nidx = bitidx + 3'd1;
                if (bitidx == 3'(DATA_BITS - 1)) nst = PARITY;
              end
      PARITY: if (last) nst = STOP;
      STOP:   if (last) begin
                // A byte already waiting starts immediately: no idle gap.
                if (thr_full) begin load = 1'b1; nst = START; end
                else nst = IDLE;
              end
      default: nst = IDLE;
    endcase
    if (load) begin
      ntsr = thr;
      npar = PAR_INIT;
      nidx = 3'd0;
    end
    // tx is driven from the next state so the line is a clean register output.
    case (nst)
      START:   tx_d = 1'b0;
      DATA:    tx_d = ntsr[0];
      PARITY:  tx_d = npar;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge mclkx16 or negedge reset) begin
    if (!reset) begin
      st       <= IDLE;
      cnt      <= 4'd0;
      bitidx   <= 3'd0;
      tsr      <= 8'd0;
      par      <= 1'b0;
      thr      <= 8'd0;
      thr_full <= 1'b0;
      write2   <= 1'b0;
      tx       <= 1'b1;
    end else begin
      st     <= nst;
      tsr    <= ntsr;
      par    <= npar;
      bitidx <= nidx;
      tx     <= tx_d;
      write2 <= write;
      cnt    <= (st == IDLE) ? 4'd0 : cnt + 4'd1;
      if (load) begin
        thr_full <= 1'b0;
      end else if (wedge && !thr_full) begin
        thr      <= data;
        thr_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset, framing, parity modes, back-to-back,
// mid-frame reset and a bench-side frame decoder standing in for the receiver.
module tb_uart_tx;
  import uart_pkg::*;

  logic       mclkx16 = 1'b0;
  logic       reset;
  logic       write, write0;
  logic [7:0] data, data0;
  logic       tx, txrdy, txempty, tx0, txrdy0, txempty0;
  logic [2:0] state, state0;

  int checks = 0;
  int errors = 0;

  uart_tx #(.PARITYMODE(1)) dut (
    .mclkx16(mclkx16), .reset(reset), .write(write), .data(data),
    .tx(tx), .txrdy(txrdy), .txempty(txempty), .state(state)
  );

  uart_tx #(.PARITYMODE(0)) dut_even (
    .mclkx16(mclkx16), .reset(reset), .write(write0), .data(data0),
    .tx(tx0), .txrdy(txrdy0), .txempty(txempty0), .state(state0)
  );

  always #5 mclkx16 = ~mclkx16;

  task automatic tick;
    @(posedge mclkx16);
    #1;
  endtask

  // Expected line bits, index 0 = start bit.
  function automatic logic [10:0] frame(input logic [7:0] d, input logic odd);
    return {1'b1, (^d) ^ odd, d, 1'b0};
  endfunction

  // Offer a byte and advance to just after the TSR-load edge.
  task automatic do_write(input logic [7:0] d);
    write = 1'b1; data = d;
    tick;
    write = 1'b0;
    tick;
  endtask

  // Samples 176 cycles starting just after the load edge; mid-bit value per bit,
  // ok cleared if any bit is not constant over its 16 cycles.
  task automatic capture_frame(output logic [10:0] bits, output logic ok);
    logic first;
    ok = 1'b1; bits = '0; first = 1'b0;
    for (int k = 0; k < FRAME_BITS * BIT_TICKS; k++) begin
      if (k % BIT_TICKS == 0) first = tx;
      else if (tx !== first) ok = 1'b0;
      if (k % BIT_TICKS == 8) bits[k / BIT_TICKS] = tx;
      tick;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      write = i[0]; data = 8'(i * 37);
      tick;
      checks++;
      if (tx !== 1'b1 || txrdy !== 1'b1 || txempty !== 1'b1 || state !== 3'(IDLE)) begin
        errors++;
        $display("FAIL reset cyc%0d: tx=%b txrdy=%b txempty=%b state=%0d, want 1 1 1 0",
                 i, tx, txrdy, txempty, state);
      end
    end
    write = 1'b0;
    tick;
    reset = 1'b1;
    tick;
  endtask

  task automatic test_single;
    logic [10:0] bits;
    logic ok;
    write = 1'b1; data = 8'h55;
    tick;
    write = 1'b0;
    checks++;
    if (txrdy !== 1'b0 || state !== 3'(IDLE) || txempty !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL single_edge: txrdy=%b state=%0d txempty=%b tx=%b, want 0 0 0 1",
               txrdy, state, txempty, tx);
    end
    tick;
    checks++;
    if (txrdy !== 1'b1 || tx !== 1'b0 || state !== 3'(START)) begin
      errors++;
      $display("FAIL single_load: txrdy=%b tx=%b state=%0d, want 1 0 1", txrdy, tx, state);
    end
    capture_frame(bits, ok);
    checks++;
    if (bits !== 11'b11_0101_0101_0 || ok !== 1'b1) begin
      errors++;
      $display("FAIL single_frame: bits=%b stable=%b, want %b stable=1",
               bits, ok, 11'b11_0101_0101_0);
    end
    checks++;
    if (state !== 3'(IDLE) || tx !== 1'b1 || txempty !== 1'b1) begin
      errors++;
      $display("FAIL single_end: state=%0d tx=%b txempty=%b, want 0 1 1", state, tx, txempty);
    end
  endtask

  task automatic test_parity_odd;
    logic [10:0] bits;
    logic ok;
    do_write(8'h01);
    capture_frame(bits, ok);
    checks++;
    if (bits[9] !== 1'b0) begin
      errors++;
      $display("FAIL parity_odd_01: got %b want 0", bits[9]);
    end
    do_write(8'h00);
    capture_frame(bits, ok);
    checks++;
    if (bits[9] !== 1'b1 || bits !== frame(8'h00, 1'b1)) begin
      errors++;
      $display("FAIL parity_odd_00: frame=%b want %b", bits, frame(8'h00, 1'b1));
    end
  endtask

  task automatic test_parity_even;
    write0 = 1'b1; data0 = 8'h01;
    tick;
    write0 = 1'b0;
    tick;
    for (int k = 0; k < 9 * BIT_TICKS + 8; k++) tick;
    checks++;
    if (tx0 !== 1'b1 || state0 !== 3'(PARITY)) begin
      errors++;
      $display("FAIL parity_even_01: tx=%b state=%0d, want 1 3", tx0, state0);
    end
    for (int k = 0; k < 24; k++) tick;
    checks++;
    if (state0 !== 3'(IDLE) || txempty0 !== 1'b1) begin
      errors++;
      $display("FAIL parity_even_end: state=%0d txempty=%b, want 0 1", state0, txempty0);
    end
  endtask

  task automatic test_back_to_back;
    logic [21:0] exp;
    logic        bad;
    int          badk;
    exp  = {frame(8'h3C, 1'b1), frame(8'hA5, 1'b1)};
    bad  = 1'b0;
    badk = -1;
    do_write(8'hA5);
    for (int k = 0; k < 2 * FRAME_BITS * BIT_TICKS; k++) begin
      if (tx !== exp[k / BIT_TICKS] && !bad) begin bad = 1'b1; badk = k; end
      if (k == 41) begin
        checks++;
        if (txrdy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_hold: txrdy=%b want 0", txrdy);
        end
      end
      if (k == 176) begin
        checks++;
        if (state !== 3'(START) || txrdy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_gap: state=%0d txrdy=%b, want 1 1", state, txrdy);
        end
      end
      write = (k == 40 || k == 80);
      if (k == 40) data = 8'h3C;
      if (k == 80) data = 8'h77;
      tick;
    end
    write = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL b2b_line: first wrong tx at cycle %0d, want bit %b", badk,
               exp[badk / BIT_TICKS]);
    end
    checks++;
    if (state !== 3'(IDLE) || tx !== 1'b1 || txempty !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drop: state=%0d tx=%b txempty=%b, want 0 1 1", state, tx, txempty);
    end
  endtask

  task automatic test_reset_midframe;
    logic [10:0] bits;
    logic ok;
    do_write(8'hC3);
    for (int k = 0; k < 4 * BIT_TICKS + 5; k++) tick;
    checks++;
    if (state !== 3'(DATA)) begin
      errors++;
      $display("FAIL midrst_pre: state=%0d want 2", state);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || state !== 3'(IDLE) || txrdy !== 1'b1 || txempty !== 1'b1) begin
      errors++;
      $display("FAIL midrst_abort: tx=%b state=%0d txrdy=%b txempty=%b, want 1 0 1 1",
               tx, state, txrdy, txempty);
    end
    tick;
    tick;
    reset = 1'b1;
    tick;
    do_write(8'hF0);
    capture_frame(bits, ok);
    checks++;
    if (bits !== frame(8'hF0, 1'b1) || ok !== 1'b1) begin
      errors++;
      $display("FAIL midrst_f0: bits=%b stable=%b, want %b", bits, ok, frame(8'hF0, 1'b1));
    end
  endtask

  task automatic test_loopback;
    logic [7:0]  lb [0:2];
    logic [10:0] bits;
    logic        ok;
    logic [7:0]  rdata;
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      do_write(lb[i]);
      capture_frame(bits, ok);
      rdata = bits[8:1];
      checks++;
      if (rdata !== lb[i]) begin
        errors++;
        $display("FAIL loop_rdata%0d: got %h want %h", i, rdata, lb[i]);
      end
      checks++;
      if ((^bits[9:1]) !== 1'b1 || bits[10] !== 1'b1 || bits[0] !== 1'b0 || ok !== 1'b1) begin
        errors++;
        $display("FAIL loop_frame%0d: bits=%b stable=%b, want odd parity, start 0, stop 1",
                 i, bits, ok);
      end
    end
  endtask

  initial begin
    reset = 1'b0; write = 1'b0; data = 8'h00; write0 = 1'b0; data0 = 8'h00;
    test_reset;
    test_single;
    test_parity_odd;
    test_parity_even;
    test_back_to_back;
    test_reset_midframe;
    test_loopback;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
